// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe move sequencer:
// FSM states, button step codes and the per-cell cursor button paths.
package ttt_pkg;

  localparam int unsigned NUM_CELLS = 9;
  localparam int unsigned SCORE_W   = 7;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned MAX_STEPS = 5;
  localparam int unsigned STEP_W    = 3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CELLS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_CHECK, S_PRESS, S_GAP, S_DONE
  } state_t;

  typedef enum logic [STEP_W-1:0] {
    STEP_NONE, STEP_U, STEP_D, STEP_L, STEP_R, STEP_C
  } step_t;

  typedef struct packed {
    logic [MAX_STEPS-1:0][STEP_W-1:0] steps;
    logic [2:0]                       len;
  } path_t;

  function automatic path_t mk_path(input step_t s0, input step_t s1, input step_t s2,
                                    input step_t s3, input step_t s4, input logic [2:0] n);
    path_t p;
    p.steps = {s4, s3, s2, s1, s0};
    p.len   = n;
    return p;
  endfunction

  // Cursor starts at the centre, visits the cell, presses C, and returns to the centre.
  function automatic path_t ttt_path(input logic [IDX_W-1:0] idx);
    path_t p;
    case (idx)
      4'd0:    p = mk_path(STEP_U, STEP_L, STEP_C, STEP_R, STEP_D, 3'd5);
      4'd1:    p = mk_path(STEP_U, STEP_C, STEP_D, STEP_NONE, STEP_NONE, 3'd3);
      4'd2:    p = mk_path(STEP_U, STEP_R, STEP_C, STEP_L, STEP_D, 3'd5);
      4'd3:    p = mk_path(STEP_L, STEP_C, STEP_R, STEP_NONE, STEP_NONE, 3'd3);
      4'd4:    p = mk_path(STEP_C, STEP_NONE, STEP_NONE, STEP_NONE, STEP_NONE, 3'd1);
      4'd5:    p = mk_path(STEP_R, STEP_C, STEP_L, STEP_NONE, STEP_NONE, 3'd3);
      4'd6:    p = mk_path(STEP_D, STEP_L, STEP_C, STEP_R, STEP_U, 3'd5);
      4'd7:    p = mk_path(STEP_D, STEP_C, STEP_U, STEP_NONE, STEP_NONE, 3'd3);
      4'd8:    p = mk_path(STEP_D, STEP_R, STEP_C, STEP_L, STEP_U, 3'd5);
      default: p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/ttt_cell_scanner.sv
// Serial signed-max over empty cells, one cell per enabled cycle; ties go to the
// higher index. The _c outputs include the cell being examined this cycle.
module ttt_cell_scanner
  import ttt_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         en,
  input  logic [NUM_CELLS*SCORE_W-1:0] scores,
  input  logic [NUM_CELLS-1:0]         occupied,
  output logic                         last_c,
  output logic [IDX_W-1:0]             best_idx_c,
  output logic                         best_valid_c
);

  logic [IDX_W-1:0]          idx;
  logic [IDX_W-1:0]          cand_idx;
  logic                      cand_valid;
  logic signed [SCORE_W-1:0] cand_score;
  logic signed [SCORE_W-1:0] cur_score;
  logic                      cur_empty;
  logic                      take;

  always_comb begin
    cur_score = '0;
    cur_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_score = scores[i*SCORE_W +: SCORE_W];
        cur_empty = ~occupied[i];
      end
    end
    // First empty cell is always taken, so no sentinel minimum is needed.
    take         = en && cur_empty && (!cand_valid || (cur_score >= cand_score));
    best_idx_c   = take ? idx : cand_idx;
    best_valid_c = cand_valid | take;
    last_c       = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      cand_idx   <= '0;
      cand_valid <= 1'b0;
      cand_score <= '0;
    end else if (clear) begin
      idx        <= '0;
      cand_idx   <= '0;
      cand_valid <= 1'b0;
      cand_score <= '0;
    end else if (en) begin
      idx <= idx + IDX_W'(1);
      if (take) begin
        cand_idx   <= idx;
        cand_valid <= 1'b1;
        cand_score <= cur_score;
      end
    end
  end

endmodule

// File: rtl/ttt_move_sequencer.sv
// Chooses a cell (scored scan or forced index) and replays its cursor button path
// to the tic_tac_toe board as single-cycle pulses separated by idle gaps.
module ttt_move_sequencer
  import ttt_pkg::*;
(
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         use_forced,
  input  logic [IDX_W-1:0]             forced_idx,
  input  logic [NUM_CELLS*SCORE_W-1:0] scores,
  input  logic [NUM_CELLS-1:0]         occupied,
  output logic                         busy,
  output logic                         done,
  output logic                         no_move,
  output logic [IDX_W-1:0]             move,
  output logic                         BtnU,
  output logic                         BtnD,
  output logic                         BtnL,
  output logic                         BtnR,
  output logic                         BtnC
);

  state_t                       state, state_n;
  logic [2:0]                   step, step_n;
  logic [IDX_W-1:0]             sel, sel_n;
  logic                         nm_flag, nm_flag_n;
  logic                         load, scan_clear, scan_en;
  logic [NUM_CELLS*SCORE_W-1:0] scores_q;
  logic [NUM_CELLS-1:0]         occ_q;
  logic [15:0]                  occ_ext;
  path_t                        path_cur, path_n;
  logic [STEP_W-1:0]            btn_n;
  logic                         scan_last_c, best_valid_c;
  logic [IDX_W-1:0]             best_idx_c;

  ttt_cell_scanner u_scanner (
    .clk          (Clk),
    .reset        (reset),
    .clear        (scan_clear),
    .en           (scan_en),
    .scores       (scores_q),
    .occupied     (occ_q),
    .last_c       (scan_last_c),
    .best_idx_c   (best_idx_c),
    .best_valid_c (best_valid_c)
  );

  assign occ_ext  = 16'(occ_q);
  assign path_cur = ttt_path(sel);

  // Next state; outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    state_n    = state;
    step_n     = step;
    sel_n      = sel;
    nm_flag_n  = nm_flag;
    load       = 1'b0;
    scan_clear = 1'b0;
    scan_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          load       = 1'b1;
          scan_clear = 1'b1;
          sel_n      = forced_idx;
          step_n     = 3'd0;
          nm_flag_n  = 1'b0;
          state_n    = use_forced ? S_CHECK : S_SCAN;
        end
      end
      S_SCAN: begin
        scan_en = 1'b1;
        if (scan_last_c) begin
          step_n = 3'd0;
          if (best_valid_c) begin
            sel_n   = best_idx_c;
            state_n = S_PRESS;
          end else begin
            nm_flag_n = 1'b1;
            state_n   = S_DONE;
          end
        end
      end
      S_CHECK: begin
        if ((sel > LAST_IDX) || occ_ext[sel]) begin
          nm_flag_n = 1'b1;
          state_n   = S_DONE;
        end else begin
          state_n = S_PRESS;
        end
      end
      S_PRESS: state_n = S_GAP;
      S_GAP: begin
        if (step == path_cur.len - 3'd1) begin
          state_n = S_DONE;
        end else begin
          step_n  = step + 3'd1;
          state_n = S_PRESS;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    path_n = ttt_path(sel_n);
    btn_n  = (state_n == S_PRESS) ? path_n.steps[step_n] : STEP_NONE;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      step     <= 3'd0;
      sel      <= '0;
      nm_flag  <= 1'b0;
      scores_q <= '0;
      occ_q    <= '0;
    end else begin
      state   <= state_n;
      step    <= step_n;
      sel     <= sel_n;
      nm_flag <= nm_flag_n;
      if (load) begin
        scores_q <= scores;
        occ_q    <= occupied;
      end
    end
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      done    <= 1'b0;
      no_move <= 1'b0;
      move    <= '0;
      BtnU    <= 1'b0;
      BtnD    <= 1'b0;
      BtnL    <= 1'b0;
      BtnR    <= 1'b0;
      BtnC    <= 1'b0;
    end else begin
      busy    <= (state_n != S_IDLE) && (state_n != S_DONE);
      done    <= (state_n == S_DONE);
      no_move <= (state_n == S_DONE) && nm_flag_n;
      if ((state_n == S_DONE) && !nm_flag_n) move <= sel_n;
      BtnU    <= (btn_n == STEP_U);
      BtnD    <= (btn_n == STEP_D);
      BtnL    <= (btn_n == STEP_L);
      BtnR    <= (btn_n == STEP_R);
      BtnC    <= (btn_n == STEP_C);
    end
  end

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Randomized scoreboard bench for ttt_move_sequencer: a behavioural model predicts
// each request's move, button string and timing; a negedge monitor compares.
module tb_ttt_move_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        use_forced = 1'b0;
  logic [3:0]  forced_idx = '0;
  logic [62:0] scores = '0;
  logic [8:0]  occupied = '0;
  logic        busy, done, no_move;
  logic [3:0]  move;
  logic        BtnU, BtnD, BtnL, BtnR, BtnC;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int         q_e0[$];
  int         q_done[$];
  logic [3:0] q_move[$];
  logic       q_nm[$];
  string      q_path[$];
  string      obs = "";
  logic [3:0] last_move = '0;
  string      paths[9] = '{"ULCRD", "UCD", "URCLD", "LCR", "C", "RCL", "DLCRU", "DCU", "DRCLU"};

  logic [4:0] mon_b;
  int         mon_rel;
  string      mon_ch;

  ttt_move_sequencer dut (
    .Clk(clk), .reset(reset), .start(start), .use_forced(use_forced),
    .forced_idx(forced_idx), .scores(scores), .occupied(occupied),
    .busy(busy), .done(done), .no_move(no_move), .move(move),
    .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .BtnC(BtnC)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=\"%s\" required=\"%s\"", name, act, exp);
    end
  endtask

  function automatic int sv(input logic [62:0] sc, input int i);
    logic signed [6:0] t;
    t = sc[i*7 +: 7];
    return int'(t);
  endfunction

  // Reference: best = highest index holding the maximum score among empty cells.
  task automatic model(input logic uf, input logic [3:0] fi, input logic [62:0] sc,
                       input logic [8:0] oc, input int e0);
    int best = -1;
    int maxv = -1000;
    int base;
    if (uf) begin
      if (fi < 9) begin
        if (!oc[fi]) best = int'(fi);
      end
    end else begin
      for (int i = 0; i < 9; i++) if (!oc[i] && sv(sc, i) > maxv) maxv = sv(sc, i);
      for (int i = 0; i < 9; i++) if (!oc[i] && sv(sc, i) == maxv) best = i;
    end
    base = uf ? 2 : 10;
    q_e0.push_back(e0);
    if (best < 0) begin
      q_done.push_back(base);
      q_move.push_back(last_move);
      q_nm.push_back(1'b1);
      q_path.push_back("");
    end else begin
      q_done.push_back(base + 2 * paths[best].len());
      q_move.push_back(4'(best));
      q_nm.push_back(1'b0);
      q_path.push_back(paths[best]);
      last_move = 4'(best);
    end
  endtask

  // Called at a negedge; coinc=1 means the DUT is in DONE, so the first edge must be ignored.
  task automatic issue(input logic uf, input logic [3:0] fi, input logic [62:0] sc,
                       input logic [8:0] oc, input bit coinc);
    logic [63:0] junk;
    use_forced = uf;
    forced_idx = fi;
    scores     = sc;
    occupied   = oc;
    start      = 1'b1;
    model(uf, fi, sc, oc, cyc + (coinc ? 2 : 1));
    repeat (coinc ? 2 : 1) @(negedge clk);
    start = 1'b0;
    junk = {$urandom(), $urandom()};
    scores     = junk[62:0];
    occupied   = 9'($urandom());
    forced_idx = 4'($urandom());
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input logic uf, input logic [3:0] fi, input logic [62:0] sc, input logic [8:0] oc);
    issue(uf, fi, sc, oc, 1'b0);
    wait_done();
    @(negedge clk);
  endtask

  function automatic logic [62:0] fill(input int v);
    logic [62:0] s;
    for (int i = 0; i < 9; i++) s[i*7 +: 7] = 7'(v);
    return s;
  endfunction

  function automatic logic [62:0] rand_scores();
    logic [62:0] s;
    for (int i = 0; i < 9; i++)
      s[i*7 +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                                 : 7'(int'($urandom_range(0, 4)) - 2);
    return s;
  endfunction

  function automatic logic [8:0] rand_occ();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return 9'($urandom());
      2:       return 9'($urandom() & $urandom());
      3:       return 9'h1FF ^ (9'd1 << $urandom_range(0, 8));
      default: return 9'h1FF;
    endcase
  endfunction

  task automatic rand_req(output logic uf, output logic [3:0] fi, output logic [62:0] sc,
                          output logic [8:0] oc);
    uf = 1'($urandom_range(0, 1));
    fi = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
    sc = rand_scores();
    oc = rand_occ();
  endtask

  task automatic reset_mid(input logic uf, input logic [3:0] fi, input logic [62:0] sc,
                           input logic [8:0] oc, input int k, input string name);
    issue(uf, fi, sc, oc, 1'b0);
    repeat (k - 1) @(negedge clk);
    chk({name, "_busy_before"}, 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk(name, 32'({busy, done, no_move, move, BtnU, BtnD, BtnL, BtnR, BtnC}), 32'd0);
    q_e0.delete(); q_done.delete(); q_move.delete(); q_nm.delete(); q_path.delete();
    obs = "";
    last_move = '0;
    @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: per-cycle invariants plus pop-and-compare on done.
  always @(negedge clk) begin
    if (!reset) begin
      mon_b = {BtnU, BtnD, BtnL, BtnR, BtnC};
      chk("btn_onehot", 32'($countones(mon_b) <= 1), 32'd1);
      if (q_e0.size() == 0) begin
        chk("idle_quiet", 32'({done, busy, mon_b}), 32'd0);
      end else begin
        mon_rel = cyc - q_e0[0] + 1;
        if (mon_rel >= 1) begin
          chk("busy", 32'(busy), 32'(mon_rel < q_done[0]));
          if (mon_b != 0) begin
            if (BtnU) mon_ch = "U";
            else if (BtnD) mon_ch = "D";
            else if (BtnL) mon_ch = "L";
            else if (BtnR) mon_ch = "R";
            else mon_ch = "C";
            chk("pulse_cycle", 32'(mon_rel), 32'(q_done[0] - 2 * q_path[0].len() + 2 * obs.len()));
            obs = {obs, mon_ch};
          end
          if (done) begin
            chk("done_cycle", 32'(mon_rel), 32'(q_done[0]));
            chk("move", 32'(move), 32'(q_move[0]));
            chk("no_move", 32'(no_move), 32'(q_nm[0]));
            chk_s("path", obs, q_path[0]);
            void'(q_e0.pop_front()); void'(q_done.pop_front()); void'(q_move.pop_front());
            void'(q_nm.pop_front()); void'(q_path.pop_front());
            obs = "";
          end else if (mon_rel > q_done[0]) begin
            chk("done_timeout", 32'(mon_rel), 32'(q_done[0]));
            void'(q_e0.pop_front()); void'(q_done.pop_front()); void'(q_move.pop_front());
            void'(q_nm.pop_front()); void'(q_path.pop_front());
            obs = "";
          end
        end
      end
    end
  end

  initial begin
    logic        uf;
    logic [3:0]  fi;
    logic [62:0] sc;
    logic [8:0]  oc;
    #1 reset = 1'b1;
    #2;
    chk("reset_outputs", 32'({busy, done, no_move, move, BtnU, BtnD, BtnL, BtnR, BtnC}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    sc = fill(0); sc[0 +: 7] = 7'(20);
    run(1'b0, 4'd0, sc, 9'h000);
    run(1'b0, 4'd0, fill(-5), 9'h000);
    sc = fill(-64); sc[14 +: 7] = 7'(63); sc[35 +: 7] = 7'(10);
    run(1'b0, 4'd0, sc, 9'b010000101);
    run(1'b0, 4'd0, rand_scores(), 9'h1FF);
    run(1'b1, 4'd4, fill(0), 9'h000);
    run(1'b1, 4'd9, fill(0), 9'h000);
    run(1'b1, 4'd3, fill(0), 9'b000001000);
    run(1'b1, 4'd15, fill(0), 9'h000);

    reset_mid(1'b0, 4'd0, fill(1), 9'h000, 5, "reset_mid_scan");
    run(1'b0, 4'd0, fill(3), 9'b100000000);
    reset_mid(1'b1, 4'd0, fill(0), 9'h000, 4, "reset_mid_press");
    run(1'b1, 4'd6, fill(0), 9'h000);

    // Back-to-back requests with start held through the DONE cycle.
    rand_req(uf, fi, sc, oc);
    issue(uf, fi, sc, oc, 1'b0);
    wait_done();
    for (int n = 0; n < 6; n++) begin
      rand_req(uf, fi, sc, oc);
      issue(uf, fi, sc, oc, 1'b1);
      wait_done();
    end
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      rand_req(uf, fi, sc, oc);
      run(uf, fi, sc, oc);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    chk("queue_empty", 32'(q_e0.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttt_move_sequencer.md
# ttt_move_sequencer

Drives the `tic_tac_toe` board's button inputs on behalf of an automatic player. It accepts either a scored move vector (nine 7-bit signed scores from the NN output flit) or a forced cell index (random or computer move). It picks the highest-scoring empty cell, then replays that cell's cursor button path as single-cycle pulses. It sits between the NN output router / move generator and `tic_tac_toe`, replacing the hand-sequenced button stimulus.

## Interface
Parameters:
- `NUM_CELLS`, 9: board cells.
- `SCORE_W`, 7: signed score width per cell.

Ports:
- `Clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `use_forced`  in  1  1 = play `forced_idx`, 0 = select from `scores`.
- `forced_idx`  in  4  forced cell index.
- `scores`  in  63  cell i score = `scores[7i+6:7i]`, two's complement.
- `occupied`  in  9  `P1 | P2` from the board.
- `busy`  out  1  high from the cycle after `start` is accepted until the DONE cycle (exclusive).
- `done`  out  1  one-cycle pulse at end of request.
- `no_move`  out  1  valid with `done`; no legal cell, so no buttons were pressed.
- `move`  out  4  chosen cell; valid with `done`; held until next `done`.
- `BtnU, BtnD, BtnL, BtnR, BtnC`  out  1 each  button pulses to `tic_tac_toe`.

## Operation
- States: IDLE, SCAN, CHECK, PRESS, GAP, DONE.
- IDLE + `start`:
  - latch `scores`, `occupied`, `forced_idx`.
  - go to SCAN if `use_forced`=0, else CHECK.
  - `start` is ignored outside IDLE.
- SCAN: 9 cycles, one cell per cycle, index 0→8.
  - Skip occupied cells.
  - The first empty cell always becomes the candidate. No sentinel minimum is used, so any score can win.
  - A later empty cell replaces the candidate if its score is ≥ the candidate's, so ties go to the higher index.
  - After cell 8: go to PRESS if a candidate exists, else DONE with `no_move`=1.
- CHECK: 1 cycle. If `forced_idx` ≥ 9 or the cell is occupied: DONE with `no_move`=1. Else PRESS.
- Button paths (cursor assumed at centre, returned to centre):
  - 0: U,L,C,R,D
  - 1: U,C,D
  - 2: U,R,C,L,D
  - 3: L,C,R
  - 4: C
  - 5: R,C,L
  - 6: D,L,C,R,U
  - 7: D,C,U
  - 8: D,R,C,L,U
- Path length N is 1, 3 or 5. Path bookkeeping:
  - PRESS: exactly one button high for 1 cycle.
  - GAP: all buttons low for 1 cycle.
  - After GAP, advance the step. After step N, go to DONE.
- DONE: 1 cycle. `done`=1, `move` updated (unchanged when `no_move`), `busy`=0, then return to IDLE.
- Buttons are mutually exclusive in every cycle.

## Timing
- Cycle 0 = edge where `start` is sampled. Outputs are registered.
- Scored path:
  - SCAN in cycles 1–9.
  - Press/gap pairs in cycles 10 to 9+2N.
  - `done` in cycle 10+2N.
  - No-move case: `done` in cycle 10.
- Forced path:
  - CHECK in cycle 1.
  - Press/gap pairs in cycles 2 to 1+2N.
  - `done` in cycle 2+2N.
  - No-move case: `done` in cycle 2.
- `start` coincident with DONE is ignored. A new request is accepted from the IDLE cycle after DONE.
- Reset values: state IDLE; `busy`, `done`, `no_move`, all Btn = 0; `move` = 0.
- Reset mid-operation: buttons drop low asynchronously, no `done` is issued, and the request is lost.

## Structure
- Package `ttt_pkg`:
  - state enum
  - button step encoding (NONE/U/D/L/R/C)
  - `NUM_CELLS`, `SCORE_W`
  - function `ttt_path(idx)` returning the step list and length N
- One sub-module, `ttt_cell_scanner`: serial signed-max over empty cells, tie-to-higher rule. Outputs candidate index and valid.
- The top level holds the FSM and the step counter.

## Test plan
- Reset: assert `reset` mid-SCAN and mid-PRESS → all outputs 0 immediately; next `start` is serviced normally.
- Cell 0 scores +20, others 0, board empty → U,L,C,R,D pulses in cycles 10,12,14,16,18; `done` in cycle 20 with `move`=0.
- All scores equal (−5), board empty → `move`=8, path D,R,C,L,U.
- Cell 2 scores +63 but occupied, cell 5 = +10, rest −64, some empty → `move`=5, pulses R,C,L.
- `occupied`=9'h1FF, scored mode → no buttons; `done`+`no_move` in cycle 10.
- Forced `forced_idx`=4 on empty cell → BtnC high in cycle 2 only, `done` in cycle 4. Forced 9, or an occupied cell → `no_move` in cycle 2.
